// File: rtl/ddr3_ui_pkg.sv
// Shared DDR3 UI definitions: command codes, bus widths and frame-writer FSM states.
package ddr3_ui_pkg;

    localparam logic [2:0] CMD_WRITE = 3'b000;
    localparam logic [2:0] CMD_READ  = 3'b001;

    localparam int ADDR_W = 28;
    localparam int DATA_W = 32;
    localparam int MASK_W = 4;

    localparam logic [1:0] ST_CALIB = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;

endpackage

// File: rtl/ddr3_frame_writer_if.sv
// Pixel stream input plus DDR3 UI write command/data bus of the frame writer.
// Optional build macro DDR3_WR_SOF_RESYNC_EN adds the s_sof start-of-frame marker.
interface ddr3_frame_writer_if #(
    parameter int ADDR_W = 28
) ();
    import ddr3_ui_pkg::*;

    logic [DATA_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;
`ifdef DDR3_WR_SOF_RESYNC_EN
    logic              s_sof;
`endif
    logic [ADDR_W-1:0] app_addr;
    logic [2:0]        app_cmd;
    logic              app_en;
    logic              app_rdy;
    logic [DATA_W-1:0] app_wdf_data;
    logic [MASK_W-1:0] app_wdf_mask;
    logic              app_wdf_wren;
    logic              app_wdf_end;
    logic              app_wdf_rdy;

    // Frame writer side: sinks the stream, drives the UI.
    modport master (
`ifdef DDR3_WR_SOF_RESYNC_EN
        input  s_sof,
`endif
        input  s_data, s_valid, app_rdy, app_wdf_rdy,
        output s_ready, app_addr, app_cmd, app_en, app_wdf_data,
        output app_wdf_mask, app_wdf_wren, app_wdf_end
    );

    // Environment side: stream source and DDR3 controller.
    modport slave (
`ifdef DDR3_WR_SOF_RESYNC_EN
        output s_sof,
`endif
        output s_data, s_valid, app_rdy, app_wdf_rdy,
        input  s_ready, app_addr, app_cmd, app_en, app_wdf_data,
        input  app_wdf_mask, app_wdf_wren, app_wdf_end
    );

endinterface

// File: rtl/ddr3_wr_fifo.sv
// Synchronous show-ahead FIFO. Exposes head and head+1 entries so the writer can
// present the following word in the same cycle the head retires.
module ddr3_wr_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_i,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic [WIDTH-1:0] rd_data_next,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count,
    output logic [CW-1:0]    count_next
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic [CW-1:0]    count_nx_s;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full         = (count_r == CNT_FULL);
    assign empty        = (count_r == {CW{1'b0}});
    assign pop_ok_s     = pop && !empty;
    assign push_ok_s    = push && (!full || pop_ok_s);
    assign rd_data      = mem_r[rd_ptr_r];
    assign rd_data_next = mem_r[rd_ptr_r + PTR_ONE];
    assign count        = count_r;
    assign count_next   = count_nx_s;

    // Occupancy after this cycle's push/pop.
    always_comb begin
        count_nx_s = count_r;
        if (push_ok_s && !pop_ok_s) begin
            count_nx_s = count_r + CNT_ONE;
        end else if (!push_ok_s && pop_ok_s) begin
            count_nx_s = count_r - CNT_ONE;
        end else begin
            count_nx_s = count_r;
        end
    end

    // Storage array; contents are don't-care once the pointers are reset.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r <= count_nx_s;
        end
    end

endmodule

// File: rtl/ddr3_frame_writer.sv
// Write-side front end for the DDR3 UI: buffers a 32-bit word stream and writes one
// word per UI command at linearly incrementing addresses, wrapping every frame.
// Optional build macro DDR3_WR_SOF_RESYNC_EN: s_sof restarts the frame at frame_base.
module ddr3_frame_writer
    import ddr3_ui_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_W     = 28,
    parameter int ADDR_STEP  = 8,
    parameter int CNT_W      = 24
) (
    input  logic                ui_clk,
    input  logic                sys_rst,
    input  logic                ui_clk_sync_rst,
    input  logic                init_calib_complete,
    input  logic [ADDR_W-1:0]   frame_base,
    input  logic [CNT_W-1:0]    frame_words,
    output logic                frame_done,
    ddr3_frame_writer_if.master bus
);
`ifdef DDR3_WR_SOF_RESYNC_EN
    localparam int FIFO_W = DATA_W + 1;
`else
    localparam int FIFO_W = DATA_W;
`endif
    localparam int FCW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [FCW-1:0]    FIFO_ONE  = FCW'(1);
    localparam logic [FCW-1:0]    FIFO_FULL = FCW'(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] STEP_A    = ADDR_W'(ADDR_STEP);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    logic              rst_s;
    logic [1:0]        state_r, state_nx_s;
    logic [ADDR_W-1:0] addr_r;
    logic [CNT_W-1:0]  cnt_r, words_r;
    logic              s_ready_r, frame_done_r;
    logic              app_en_r, app_wren_r, busy_r, cmd_ok_r, dat_ok_r;
    logic [DATA_W-1:0] app_wdf_data_r;

    logic              push_s;
    logic [FIFO_W-1:0] fifo_wr_s, fifo_rd_s, fifo_rd_next_s, load_word_s;
    logic              fifo_full_s, fifo_empty_s;
    logic [FCW-1:0]    fifo_count_s, fifo_count_nx_s;
    logic              cmd_acc_s, dat_acc_s, complete_s, wrap_s;
    logic              load_head_s, load_next_s, head_sof_s, next_sof_s, load_sof_s;

    assign rst_s  = !sys_rst || ui_clk_sync_rst;
    assign push_s = bus.s_valid && s_ready_r;

`ifdef DDR3_WR_SOF_RESYNC_EN
    assign fifo_wr_s  = {bus.s_sof, bus.s_data};
    assign head_sof_s = fifo_rd_s[DATA_W];
    assign next_sof_s = fifo_rd_next_s[DATA_W];
`else
    assign fifo_wr_s  = bus.s_data;
    assign head_sof_s = 1'b0;
    assign next_sof_s = 1'b0;
`endif

    ddr3_wr_fifo #(.WIDTH(FIFO_W), .DEPTH(FIFO_DEPTH), .CW(FCW)) u_fifo (
        .clk          (ui_clk),
        .rst_i        (rst_s),
        .push         (push_s),
        .wr_data      (fifo_wr_s),
        .pop          (complete_s),
        .rd_data      (fifo_rd_s),
        .rd_data_next (fifo_rd_next_s),
        .full         (fifo_full_s),
        .empty        (fifo_empty_s),
        .count        (fifo_count_s),
        .count_next   (fifo_count_nx_s)
    );

    // A word retires once both its command and its data beat have been taken.
    assign cmd_acc_s   = app_en_r && bus.app_rdy;
    assign dat_acc_s   = app_wren_r && bus.app_wdf_rdy;
    assign complete_s  = busy_r && (cmd_ok_r || cmd_acc_s) && (dat_ok_r || dat_acc_s);
    assign wrap_s      = (words_r != {CNT_W{1'b0}}) && (cnt_r == words_r - CNT_ONE);
    assign load_head_s = (state_r == ST_RUN) && !busy_r && !fifo_empty_s;
    assign load_next_s = complete_s && (fifo_count_s > FIFO_ONE);

    // Pick the word (and its sof marker) entering the output beat this cycle.
    always_comb begin
        load_word_s = fifo_rd_s;
        load_sof_s  = 1'b0;
        if (load_next_s) begin
            load_word_s = fifo_rd_next_s;
            load_sof_s  = next_sof_s;
        end else if (load_head_s) begin
            load_word_s = fifo_rd_s;
            load_sof_s  = head_sof_s;
        end else begin
            load_sof_s  = 1'b0;
        end
    end

    // Bring-up sequencing; once running only reset leaves RUN.
    always_comb begin
        case (state_r)
            ST_CALIB: state_nx_s = init_calib_complete ? ST_LOAD : ST_CALIB;
            ST_LOAD:  state_nx_s = ST_RUN;
            ST_RUN:   state_nx_s = ST_RUN;
            default:  state_nx_s = ST_CALIB;
        endcase
    end

    // State register.
    always_ff @(posedge ui_clk) begin
        if (rst_s) begin
            state_r <= ST_CALIB;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Frame position: address of the current word and its index within the frame.
    always_ff @(posedge ui_clk) begin
        if (rst_s) begin
            addr_r  <= {ADDR_W{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            words_r <= {CNT_W{1'b0}};
        end else if ((state_r == ST_LOAD) || load_sof_s) begin
            addr_r  <= frame_base;
            cnt_r   <= {CNT_W{1'b0}};
            words_r <= frame_words;
        end else if (complete_s && wrap_s) begin
            addr_r  <= frame_base;
            cnt_r   <= {CNT_W{1'b0}};
            words_r <= frame_words;
        end else if (complete_s) begin
            addr_r  <= addr_r + STEP_A;
            cnt_r   <= (cnt_r == {CNT_W{1'b1}}) ? cnt_r : cnt_r + CNT_ONE;
        end
    end

    // Output beat: present a FIFO word and retire each UI side independently.
    always_ff @(posedge ui_clk) begin
        if (rst_s) begin
            app_en_r       <= 1'b0;
            app_wren_r     <= 1'b0;
            busy_r         <= 1'b0;
            cmd_ok_r       <= 1'b0;
            dat_ok_r       <= 1'b0;
            app_wdf_data_r <= {DATA_W{1'b0}};
        end else if (complete_s) begin
            cmd_ok_r   <= 1'b0;
            dat_ok_r   <= 1'b0;
            busy_r     <= load_next_s;
            app_en_r   <= load_next_s;
            app_wren_r <= load_next_s;
            if (load_next_s) begin
                app_wdf_data_r <= load_word_s[DATA_W-1:0];
            end
        end else if (busy_r) begin
            if (cmd_acc_s) begin
                app_en_r <= 1'b0;
                cmd_ok_r <= 1'b1;
            end
            if (dat_acc_s) begin
                app_wren_r <= 1'b0;
                dat_ok_r   <= 1'b1;
            end
        end else if (load_head_s) begin
            busy_r         <= 1'b1;
            app_en_r       <= 1'b1;
            app_wren_r     <= 1'b1;
            app_wdf_data_r <= load_word_s[DATA_W-1:0];
        end
    end

    // Stream ready looks at next-cycle occupancy so a registered ready never overfills.
    always_ff @(posedge ui_clk) begin
        if (rst_s) begin
            s_ready_r    <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            s_ready_r    <= (state_nx_s == ST_RUN) && (fifo_count_nx_s != FIFO_FULL);
            frame_done_r <= complete_s && wrap_s;
        end
    end

    assign bus.s_ready      = s_ready_r;
    assign bus.app_addr     = addr_r;
    assign bus.app_cmd      = CMD_WRITE;
    assign bus.app_en       = app_en_r;
    assign bus.app_wdf_data = app_wdf_data_r;
    assign bus.app_wdf_mask = {MASK_W{1'b0}};
    assign bus.app_wdf_wren = app_wren_r;
    assign bus.app_wdf_end  = app_wren_r;
    assign frame_done       = frame_done_r;

endmodule

// File: tb/tb_ddr3_frame_writer.sv
// Scoreboard bench for ddr3_frame_writer: stimulus pushes expected writes, a monitor
// pairs accepted commands with accepted data beats and compares them in order.
module tb_ddr3_frame_writer;
    import ddr3_ui_pkg::*;

    typedef struct packed {
        logic [27:0] addr;
        logic [31:0] data;
        logic        done;
    } exp_t;

    logic        clk;
    logic        sys_rst, ui_clk_sync_rst, init_calib_complete, frame_done;
    logic [27:0] frame_base;
    logic [23:0] frame_words;

    int   nchk = 0;
    int   nfail = 0;
    int   cyc = 0;
    exp_t exp_q[$];
    logic [27:0] cq[$];
    logic [31:0] dq[$];
    int   comp_cyc[$];
    logic done_pend, hold_cmd, hold_dat;
    logic [27:0] prev_addr, mon_a;
    logic [31:0] prev_data, mon_d;
    exp_t mon_e;
    int   acc;

    ddr3_frame_writer_if #(.ADDR_W(28)) bus ();

    ddr3_frame_writer #(.FIFO_DEPTH(16), .ADDR_W(28), .ADDR_STEP(8), .CNT_W(24)) dut (
        .ui_clk              (clk),
        .sys_rst             (sys_rst),
        .ui_clk_sync_rst     (ui_clk_sync_rst),
        .init_calib_complete (init_calib_complete),
        .frame_base          (frame_base),
        .frame_words         (frame_words),
        .frame_done          (frame_done),
        .bus                 (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog act=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        nchk++;
        if (act !== req) begin
            nfail++;
            $display("FAIL %s act=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: pairs UI command and data acceptances, compares with scoreboard.
    initial begin
        done_pend = 1'b0;
        hold_cmd  = 1'b0;
        hold_dat  = 1'b0;
        forever begin
            @(negedge clk);
            if (!sys_rst || ui_clk_sync_rst) begin
                exp_q.delete();
                cq.delete();
                dq.delete();
                done_pend = 1'b0;
                hold_cmd  = 1'b0;
                hold_dat  = 1'b0;
            end else begin
                if (done_pend || frame_done) chk("frame_done", frame_done, done_pend);
                done_pend = 1'b0;
                if (hold_cmd) begin
                    chk("cmd_hold_en", bus.app_en, 1);
                    chk("cmd_hold_addr", bus.app_addr, prev_addr);
                end
                if (hold_dat) begin
                    chk("dat_hold_wren", bus.app_wdf_wren, 1);
                    chk("dat_hold_data", bus.app_wdf_data, prev_data);
                end
                if (bus.app_wdf_wren || bus.app_wdf_end) chk("wdf_end", bus.app_wdf_end, bus.app_wdf_wren);
                hold_cmd  = bus.app_en && !bus.app_rdy;
                prev_addr = bus.app_addr;
                hold_dat  = bus.app_wdf_wren && !bus.app_wdf_rdy;
                prev_data = bus.app_wdf_data;
                if (bus.app_en && bus.app_rdy) cq.push_back(bus.app_addr);
                if (bus.app_wdf_wren && bus.app_wdf_rdy) dq.push_back(bus.app_wdf_data);
                if (cq.size() > 0 && dq.size() > 0) begin
                    mon_a = cq.pop_front();
                    mon_d = dq.pop_front();
                    if (exp_q.size() == 0) begin
                        nchk++;
                        nfail++;
                        $display("FAIL unexpected_write act=%0h/%0h required=none", mon_a, mon_d);
                    end else begin
                        mon_e = exp_q.pop_front();
                        chk("wr_addr", mon_a, mon_e.addr);
                        chk("wr_data", mon_d, mon_e.data);
                        done_pend = mon_e.done;
                        comp_cyc.push_back(cyc);
                    end
                end
            end
        end
    end

    // Offer one word; called and returns just after a rising edge.
    task automatic push_word(input logic [31:0] d, input logic [27:0] ea, input logic ed);
        int t;
        t = 0;
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        @(negedge clk);
        while (!bus.s_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("push_accept", bus.s_ready, 1);
        if (bus.s_ready) exp_q.push_back('{ea, d, ed});
        @(posedge clk);
        #1;
        bus.s_valid = 1'b0;
`ifdef DDR3_WR_SOF_RESYNC_EN
        bus.s_sof = 1'b0;
`endif
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk("drain_left", exp_q.size(), 0);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    initial begin
        sys_rst = 1'b0;
        ui_clk_sync_rst = 1'b0;
        init_calib_complete = 1'b0;
        frame_base = 28'h100;
        frame_words = 24'd4;
        bus.s_valid = 1'b0;
        bus.s_data = 32'h0;
        bus.app_rdy = 1'b0;
        bus.app_wdf_rdy = 1'b0;
`ifdef DDR3_WR_SOF_RESYNC_EN
        bus.s_sof = 1'b0;
`endif
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_s_ready", bus.s_ready, 0);
        chk("rst_app_en", bus.app_en, 0);
        chk("rst_wren", bus.app_wdf_wren, 0);
        chk("rst_end", bus.app_wdf_end, 0);
        chk("rst_addr", bus.app_addr, 0);
        chk("rst_cmd", bus.app_cmd, 0);
        chk("rst_mask", bus.app_wdf_mask, 0);
        chk("rst_done", frame_done, 0);
        @(posedge clk); #1;
        sys_rst = 1'b1;
        ui_clk_sync_rst = 1'b1;
        @(negedge clk);
        chk("uirst_s_ready", bus.s_ready, 0);
        @(posedge clk); #1;
        ui_clk_sync_rst = 1'b0;

        // 1: calibration gate
        repeat (100) begin
            @(negedge clk);
            chk("calib_s_ready", bus.s_ready, 0);
            chk("calib_app_en", bus.app_en, 0);
        end
        @(posedge clk); #1;
        init_calib_complete = 1'b1;
        bus.app_rdy = 1'b1;
        bus.app_wdf_rdy = 1'b1;
        for (int i = 0; i < 3 && !bus.s_ready; i++) @(negedge clk);
        chk("calib_ready_3", bus.s_ready, 1);
        @(posedge clk); #1;

        // 2: streaming, frame of 4 at 0x100
        comp_cyc.delete();
        push_word(32'hA0, 28'h100, 1'b0);
        push_word(32'hA1, 28'h108, 1'b0);
        push_word(32'hA2, 28'h110, 1'b0);
        push_word(32'hA3, 28'h118, 1'b1);
        push_word(32'hA4, 28'h100, 1'b0);
        drain();
        chk("b2b_count", comp_cyc.size(), 5);
        for (int i = 1; i < 5 && i < comp_cyc.size(); i++)
            chk("b2b_gap", comp_cyc[i] - comp_cyc[i-1], 1);

        // 3: split handshakes
        bus.app_rdy = 1'b0;
        bus.app_wdf_rdy = 1'b0;
        push_word(32'hB0, 28'h108, 1'b0);
        push_word(32'hB1, 28'h110, 1'b0);
        @(negedge clk);
        chk("split_en", bus.app_en, 1);
        chk("split_wren", bus.app_wdf_wren, 1);
        chk("split_addr", bus.app_addr, 28'h108);
        chk("split_data", bus.app_wdf_data, 32'hB0);
        @(posedge clk); #1;
        bus.app_rdy = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("cmd_first_en", bus.app_en, 0);
        chk("cmd_first_wren", bus.app_wdf_wren, 1);
        @(posedge clk); #1;
        bus.app_rdy = 1'b0;
        bus.app_wdf_rdy = 1'b1;
        @(posedge clk); #1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("dat_first_en", bus.app_en, 1);
        chk("dat_first_wren", bus.app_wdf_wren, 0);
        @(posedge clk); #1;
        bus.app_rdy = 1'b1;
        drain();

        // 4: backpressure, FIFO fills to 16
        bus.app_rdy = 1'b0;
        acc = 0;
        for (int i = 0; i < 40; i++) begin
            bus.s_valid = 1'b1;
            bus.s_data = 32'hC0 + acc;
            @(negedge clk);
            if (bus.s_ready) begin
                exp_q.push_back('{28'h100 + 28'(8 * ((3 + acc) % 4)), 32'hC0 + acc, ((3 + acc) % 4) == 3});
                acc++;
            end
            @(posedge clk); #1;
        end
        bus.s_valid = 1'b0;
        @(negedge clk);
        chk("bp_accepted", acc, 16);
        chk("bp_s_ready", bus.s_ready, 0);
        @(posedge clk); #1;
        bus.app_rdy = 1'b1;
        drain();

        // 5: reset mid-run
        bus.app_rdy = 1'b0;
        bus.app_wdf_rdy = 1'b0;
        push_word(32'hD0, 28'h118, 1'b1);
        for (int i = 0; i < 10 && !bus.app_en; i++) @(negedge clk);
        chk("d0_presented", bus.app_en, 1);
        @(posedge clk); #1;
        sys_rst = 1'b0;
        @(posedge clk); #1;
        sys_rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_en", bus.app_en, 0);
        chk("mid_rst_wren", bus.app_wdf_wren, 0);
        chk("mid_rst_addr", bus.app_addr, 0);
        chk("mid_rst_s_ready", bus.s_ready, 0);
        chk("mid_rst_state", dut.state_r, ST_CALIB);
        chk("mid_rst_fifo_empty", dut.u_fifo.empty, 1);
        @(posedge clk); #1;
        bus.app_rdy = 1'b1;
        bus.app_wdf_rdy = 1'b1;
        push_word(32'hE0, 28'h100, 1'b0);
        push_word(32'hE1, 28'h108, 1'b0);
        drain();

        // 6: frame of 8, frame_base re-latched at wrap (and sof resync when built in)
        frame_base = 28'h200;
        frame_words = 24'd8;
        ui_clk_sync_rst = 1'b1;
        @(posedge clk); #1;
        ui_clk_sync_rst = 1'b0;
        push_word(32'hF0, 28'h200, 1'b0);
        frame_base = 28'h300;
        for (int k = 1; k < 8; k++)
            push_word(32'hF0 + k, 28'h200 + 28'(8 * k), k == 7);
        push_word(32'hF8, 28'h300, 1'b0);
`ifdef DDR3_WR_SOF_RESYNC_EN
        push_word(32'h90, 28'h308, 1'b0);
        push_word(32'h91, 28'h310, 1'b0);
        bus.s_sof = 1'b1;
        push_word(32'h92, 28'h300, 1'b0);
        push_word(32'h93, 28'h308, 1'b0);
`endif
        drain();

        chk("cmd_leftover", cq.size(), 0);
        chk("dat_leftover", dq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end

endmodule
